// File: rtl/fetch_queue.sv
// fetch_queue: request/response instruction fetch engine feeding decode through a QDEPTH-entry {pc, insn} queue
module fetch_queue #(
  parameter int DWIDTH = 32,
  parameter int AWIDTH = 32,
  parameter logic [AWIDTH-1:0] BASEADDR = AWIDTH'(32'h0100_0000),
  parameter int QDEPTH = 4
) (
  input  logic              clk,
  input  logic              rst,
  output logic              imem_req_valid_o,
  input  logic              imem_req_ready_i,
  output logic [AWIDTH-1:0] imem_req_addr_o,
  input  logic              imem_rsp_valid_i,
  input  logic [DWIDTH-1:0] imem_rsp_data_i,
  input  logic              redirect_i,
  input  logic [AWIDTH-1:0] redirect_pc_i,
  output logic              insn_valid_o,
  input  logic              insn_ready_i,
  output logic [AWIDTH-1:0] pc_o,
  output logic [DWIDTH-1:0] insn_o
);
  localparam int PW = $clog2(QDEPTH);
  localparam int CW = PW + 1;
  logic [AWIDTH-1:0] fpc, rpc, rd_pc;
  logic [CW-1:0] count, out, drop;
  logic [PW-1:0] hp, tp;
  logic [AWIDTH-1:0] pcq [QDEPTH];
  logic [DWIDTH-1:0] dq [QDEPTH];
  logic fire, push, pop;
  assign rd_pc = redirect_pc_i & ~AWIDTH'(3);
  assign imem_req_valid_o = !rst && !redirect_i && (({1'b0, count} + {1'b0, out}) < (CW+1)'(QDEPTH));
  assign imem_req_addr_o = fpc;
  assign fire = imem_req_valid_o && imem_req_ready_i;
  assign push = !rst && !redirect_i && imem_rsp_valid_i && drop == '0;
  assign insn_valid_o = !rst && count != '0;
  assign pop = insn_valid_o && insn_ready_i;
  assign pc_o = insn_valid_o ? pcq[hp] : '0;
  assign insn_o = insn_valid_o ? dq[hp] : '0;
  // rpc is the PC of the next response that will be queued; dropped responses never advance it
  always_ff @(posedge clk) begin
    if (rst) begin
      fpc <= BASEADDR;
      rpc <= BASEADDR;
      count <= '0;
      out <= '0;
      drop <= '0;
      hp <= '0;
      tp <= '0;
    end else begin
      out <= out + CW'(fire) - CW'(imem_rsp_valid_i);
      if (redirect_i) begin
        fpc <= rd_pc;
        rpc <= rd_pc;
        count <= '0;
        hp <= '0;
        tp <= '0;
        drop <= out - CW'(imem_rsp_valid_i);
      end else begin
        if (fire) fpc <= fpc + AWIDTH'(4);
        if (imem_rsp_valid_i && drop != '0) drop <= drop - CW'(1);
        if (push) begin
          tp <= tp + PW'(1);
          rpc <= rpc + AWIDTH'(4);
        end
        if (pop) hp <= hp + PW'(1);
        count <= count + CW'(push) - CW'(pop);
      end
    end
  end
  always_ff @(posedge clk) begin
    if (push) begin
      pcq[tp] <= rpc;
      dq[tp] <= imem_rsp_data_i;
    end
  end
endmodule

// File: tb/tb_fetch_queue.sv
// tb_fetch_queue: randomized fetch_queue bench against a queue-based memory/decode model
module tb_fetch_queue;
  localparam int QD = 4;
  localparam logic [31:0] BASE = 32'h0100_0000;
  typedef struct {logic [31:0] addr; int due; bit stale;} pend_t;
  typedef struct {logic [31:0] pc; logic [31:0] insn;} ent_t;
  logic clk = 0;
  logic rst = 1;
  logic imem_req_valid_o, imem_req_ready_i = 0, imem_rsp_valid_i = 0;
  logic [31:0] imem_req_addr_o, imem_rsp_data_i = 0;
  logic redirect_i = 0, insn_valid_o, insn_ready_i = 0;
  logic [31:0] redirect_pc_i = 0, pc_o, insn_o;
  always #5 clk = ~clk;
  fetch_queue dut (
    .clk(clk), .rst(rst),
    .imem_req_valid_o(imem_req_valid_o), .imem_req_ready_i(imem_req_ready_i), .imem_req_addr_o(imem_req_addr_o),
    .imem_rsp_valid_i(imem_rsp_valid_i), .imem_rsp_data_i(imem_rsp_data_i),
    .redirect_i(redirect_i), .redirect_pc_i(redirect_pc_i),
    .insn_valid_o(insn_valid_o), .insn_ready_i(insn_ready_i), .pc_o(pc_o), .insn_o(insn_o)
  );
  int checks = 0, fails = 0;
  int cyc = 0, lat = 1, pr = 100, pd = 100, prd = 0;
  bit rst_req = 1, force_rd = 0;
  logic [31:0] rd_target = 0, mfpc = BASE;
  pend_t pend[$];
  ent_t q[$];
  logic o_rv, o_iv;
  logic [31:0] o_ra, o_pc, o_insn;
  bit fired, popped;
  task automatic chk(string nm, logic [63:0] act, logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask
  function automatic logic [31:0] mem(logic [31:0] a);
    return (a * 32'h0001_0003) ^ 32'h1234_5678;
  endfunction
  task automatic cycle();
    bit rsp_now, exp_rv, exp_iv, fire, pop;
    pend_t e;
    @(negedge clk);
    rst = rst_req;
    rsp_now = !rst && pend.size() > 0 && pend[0].due <= cyc;
    imem_rsp_valid_i = rst ? 1'($urandom_range(1)) : rsp_now;
    imem_rsp_data_i = rsp_now ? mem(pend[0].addr) : $urandom;
    imem_req_ready_i = $urandom_range(99) < pr;
    insn_ready_i = $urandom_range(99) < pd;
    redirect_i = !rst && (force_rd || $urandom_range(99) < prd);
    redirect_pc_i = force_rd ? rd_target : BASE + 32'($urandom_range(4095));
    force_rd = 0;
    #1;
    exp_rv = !rst && !redirect_i && (q.size() + pend.size() < QD);
    exp_iv = !rst && q.size() != 0;
    chk("req_valid", imem_req_valid_o, exp_rv);
    if (exp_rv) chk("req_addr", imem_req_addr_o, mfpc);
    chk("insn_valid", insn_valid_o, exp_iv);
    chk("pc", pc_o, exp_iv ? q[0].pc : 32'h0);
    chk("insn", insn_o, exp_iv ? q[0].insn : 32'h0);
    o_rv = imem_req_valid_o;
    o_ra = imem_req_addr_o;
    o_iv = insn_valid_o;
    o_pc = pc_o;
    o_insn = insn_o;
    fire = exp_rv && imem_req_ready_i;
    pop = exp_iv && insn_ready_i;
    fired = imem_req_valid_o && imem_req_ready_i;
    popped = insn_valid_o && insn_ready_i;
    @(posedge clk);
    if (rst) begin
      mfpc = BASE;
      q.delete();
      pend.delete();
      cyc = 0;
    end else begin
      if (rsp_now) e = pend.pop_front();
      if (redirect_i) begin
        q.delete();
        foreach (pend[i]) pend[i].stale = 1;
        mfpc = {redirect_pc_i[31:2], 2'b00};
      end else begin
        if (pop) void'(q.pop_front());
        if (rsp_now && !e.stale) q.push_back('{e.addr, mem(e.addr)});
        if (fire) begin
          pend.push_back('{mfpc, cyc + lat, 1'b0});
          mfpc = mfpc + 32'd4;
        end
      end
      cyc++;
    end
  endtask
  task automatic drain();
    pr = 0;
    pd = 100;
    prd = 0;
    repeat (8) cycle();
  endtask
  task automatic first_head(string nm, logic [31:0] exp_pc);
    bit found = 0;
    for (int i = 0; i < 20 && !found; i++) begin
      cycle();
      found = o_iv;
    end
    chk({nm, "_seen"}, found, 1);
    chk({nm, "_pc"}, o_pc, exp_pc);
  endtask
  initial begin
    int n, k;
    logic [31:0] wexp [4];
    wexp = '{32'hFFFF_FFF8, 32'hFFFF_FFFC, 32'h0000_0000, 32'h0000_0004};
    cycle();
    cycle();
    chk("rst_req_valid", o_rv, 0);
    chk("rst_insn_valid", o_iv, 0);
    rst_req = 0;
    for (int i = 0; i < 5; i++) begin
      cycle();
      if (i == 0) begin
        chk("t1_req_valid0", o_rv, 1);
        chk("t1_addr0", o_ra, 32'h0100_0000);
      end
      if (i == 1) chk("t1_empty1", o_iv, 0);
      if (i >= 2) begin
        chk("t1_head_valid", o_iv, 1);
        chk("t1_head_pc", o_pc, 32'h0100_0000 + 32'(4 * (i - 2)));
        chk("t1_head_insn", o_insn, mem(32'h0100_0000 + 32'(4 * (i - 2))));
      end
    end
    drain();
    pd = 0;
    pr = 100;
    n = 0;
    repeat (10) begin
      cycle();
      n += int'(fired);
    end
    chk("t2_accepts", n, 4);
    chk("t2_req_stopped", o_rv, 0);
    pd = 100;
    n = 0;
    repeat (8) begin
      cycle();
      n += int'(popped);
    end
    chk("t2_pops", n, 8);
    lat = 3;
    drain();
    pr = 100;
    cycle();
    cycle();
    pr = 0;
    rd_target = 32'h0100_0103;
    force_rd = 1;
    cycle();
    pr = 100;
    cycle();
    chk("t3_req_valid", o_rv, 1);
    chk("t3_addr", o_ra, 32'h0100_0100);
    first_head("t3_head", 32'h0100_0100);
    drain();
    pr = 100;
    cycle();
    cycle();
    pr = 0;
    cycle();
    rd_target = 32'h0100_0200;
    force_rd = 1;
    cycle();
    chk("t4_empty_at_redirect", o_iv, 0);
    pr = 100;
    first_head("t4_head", 32'h0100_0200);
    drain();
    lat = 1;
    pr = 100;
    rd_target = 32'hFFFF_FFF9;
    force_rd = 1;
    cycle();
    k = 0;
    for (int i = 0; i < 20 && k < 4; i++) begin
      cycle();
      if (fired) begin
        chk("t5_wrap_addr", o_ra, wexp[k]);
        k++;
      end
    end
    chk("t5_wrap_count", k, 4);
    pd = 0;
    pr = 100;
    repeat (8) cycle();
    chk("t6_full", o_iv, 1);
    rst_req = 1;
    cycle();
    chk("t6_rst_valid", o_iv, 0);
    chk("t6_rst_pc", o_pc, 0);
    chk("t6_rst_insn", o_insn, 0);
    chk("t6_rst_req", o_rv, 0);
    rst_req = 0;
    pd = 100;
    cycle();
    chk("t6_restart_valid", o_rv, 1);
    chk("t6_restart_addr", o_ra, BASE);
    for (int p = 0; p < 6; p++) begin
      lat = $urandom_range(1, 4);
      pr = $urandom_range(30, 100);
      pd = $urandom_range(30, 100);
      prd = $urandom_range(0, 6);
      if (p == 3) begin
        rst_req = 1;
        cycle();
        rst_req = 0;
      end
      repeat (600) cycle();
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
    $finish;
  end
endmodule
